axis_rr_arbiter: RTL and testbench

// - Two-input, packet-atomic round-robin arbiter for the 8-bit AXI-Stream test datapath.
// - Merges two producer streams (e.g. two axis_source instances) onto the single slave port of a processing stage (axis_add1).
// - Once a port is granted, its packet passes whole, up to and including the TLAST beat; ports then alternate.
// - Keeps per-port packet counters for the testbench.

---
 rtl/axis_rr_arbiter_pkg.sv | 17 +
 rtl/rr_pick2.sv | 18 +
 rtl/axis_rr_arbiter.sv | 111 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter family.
package axis_rr_arbiter_pkg;

  localparam int unsigned AxisDataW = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Priority encoding: 0 favours port 0, 1 favours port 1. After port 0 finishes
  // a packet the priority moves to port 1, and vice versa.
  function automatic logic next_prio(logic [1:0] finished_grant);
    return finished_grant[0];
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: returns a one-hot grant from req and prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Two-input packet-atomic round-robin AXI-Stream arbiter with per-port packet counters.
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = AxisDataW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              S0_AXIS_TVALID,
  input  logic [DATA_W-1:0] S0_AXIS_TDATA,
  input  logic              S0_AXIS_TLAST,
  output logic              S0_AXIS_TREADY,

  input  logic              S1_AXIS_TVALID,
  input  logic [DATA_W-1:0] S1_AXIS_TDATA,
  input  logic              S1_AXIS_TLAST,
  output logic              S1_AXIS_TREADY,

  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,

  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  arb_state_e       state_q;
  logic [1:0]       grant_q;
  logic             prio_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic [1:0]       pick;
  logic             pkt_end;

  rr_pick2 u_pick (
    .req  ({S1_AXIS_TVALID, S0_AXIS_TVALID}),
    .prio (prio_q),
    .gnt  (pick)
  );

  // Combinational pass-through from the granted port; everything parks at 0 otherwise.
  always_comb begin
    M_AXIS_TVALID  = 1'b0;
    M_AXIS_TDATA   = '0;
    M_AXIS_TLAST   = 1'b0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    if (state_q == StBusy) begin
      unique case (grant_q)
        2'b01: begin
          M_AXIS_TVALID  = S0_AXIS_TVALID;
          M_AXIS_TDATA   = S0_AXIS_TDATA;
          M_AXIS_TLAST   = S0_AXIS_TLAST;
          S0_AXIS_TREADY = M_AXIS_TREADY;
        end
        2'b10: begin
          M_AXIS_TVALID  = S1_AXIS_TVALID;
          M_AXIS_TDATA   = S1_AXIS_TDATA;
          M_AXIS_TLAST   = S1_AXIS_TLAST;
          S1_AXIS_TREADY = M_AXIS_TREADY;
        end
        default: ;
      endcase
    end
  end

  assign pkt_end = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick != 2'b00) begin
            grant_q <= pick;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (pkt_end) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            prio_q  <= next_prio(grant_q);
            if (grant_q[0]) begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end else begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == StBusy);
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: queued sources, random stalls, behavioural arbitration model.
module tb_axis_rr_arbiter;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s0_v = 1'b0, s0_l = 1'b0, s0_r;
  logic          s1_v = 1'b0, s1_l = 1'b0, s1_r;
  logic [DW-1:0] s0_d = '0, s1_d = '0;
  logic          m_v, m_l;
  logic          m_r = 1'b1;
  logic [DW-1:0] m_d;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S0_AXIS_TVALID (s0_v),
    .S0_AXIS_TDATA  (s0_d),
    .S0_AXIS_TLAST  (s0_l),
    .S0_AXIS_TREADY (s0_r),
    .S1_AXIS_TVALID (s1_v),
    .S1_AXIS_TDATA  (s1_d),
    .S1_AXIS_TLAST  (s1_l),
    .S1_AXIS_TREADY (s1_r),
    .M_AXIS_TVALID  (m_v),
    .M_AXIS_TDATA   (m_d),
    .M_AXIS_TLAST   (m_l),
    .M_AXIS_TREADY  (m_r),
    .grant          (grant),
    .busy           (busy),
    .pkt_cnt0       (cnt0),
    .pkt_cnt1       (cnt1)
  );

  // Beats are {last, data}. src_q feeds the drivers, exp_q is the scoreboard.
  logic [8:0] src_q [2][$];
  logic [8:0] exp_q [2][$];
  int         gap [2];
  bit         hs_seen [2];
  bit         rand_gaps = 0;
  bit         rand_ready = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // Reference model state: owner -1 means no port holds the output.
  int owner = -1;
  int prio = 0;
  int mcnt [2];
  int order_q[$];
  int hs0_cyc_q[$];

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void drive_src();
    s0_v = (src_q[0].size() > 0) && (gap[0] == 0);
    s0_d = (src_q[0].size() > 0) ? src_q[0][0][7:0] : 8'h00;
    s0_l = (src_q[0].size() > 0) ? src_q[0][0][8] : 1'b0;
    s1_v = (src_q[1].size() > 0) && (gap[1] == 0);
    s1_d = (src_q[1].size() > 0) ? src_q[1][0][7:0] : 8'h00;
    s1_l = (src_q[1].size() > 0) ? src_q[1][0][8] : 1'b0;
  endfunction

  function automatic void enq(int p, int len, int base, bit rnd);
    logic [8:0] b;
    for (int i = 0; i < len; i++) begin
      b[7:0] = rnd ? 8'($urandom) : 8'(base + i);
      b[8]   = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    drive_src();
  endfunction

  // Source and sink drivers: advance after each observed handshake.
  initial begin
    gap[0] = 0;
    gap[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (hs_seen[p] && src_q[p].size() > 0) begin
          if (src_q[p][0][8] && rand_gaps) gap[p] = $urandom_range(0, 3);
          void'(src_q[p].pop_front());
        end else if (gap[p] > 0) begin
          gap[p]--;
        end
      end
      drive_src();
      m_r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare DUT against the model, consume scoreboard entries, then step the model.
  initial begin
    mcnt[0] = 0;
    mcnt[1] = 0;
    forever begin
      logic       v [2];
      logic [7:0] d [2];
      logic       l [2];
      logic [8:0] e;
      @(negedge clk);
      cyc++;
      v[0] = s0_v; v[1] = s1_v;
      d[0] = s0_d; d[1] = s1_d;
      l[0] = s0_l; l[1] = s1_l;
      if (!rst_n) begin
        owner = -1;
        prio = 0;
        mcnt[0] = 0;
        mcnt[1] = 0;
      end
      chk("grant", grant, (owner < 0) ? 0 : (owner == 0 ? 1 : 2));
      chk("busy", busy, owner >= 0);
      chk("s0_tready", s0_r, (owner == 0) && m_r);
      chk("s1_tready", s1_r, (owner == 1) && m_r);
      chk("m_tvalid", m_v, (owner >= 0) ? v[owner] : 0);
      chk("m_tdata", m_d, (owner >= 0) ? d[owner] : 0);
      chk("m_tlast", m_l, (owner >= 0) ? l[owner] : 0);
      chk("pkt_cnt0", cnt0, mcnt[0]);
      chk("pkt_cnt1", cnt1, mcnt[1]);
      hs_seen[0] = rst_n && s0_v && s0_r;
      hs_seen[1] = rst_n && s1_v && s1_r;
      if (rst_n && owner >= 0) begin
        if (v[owner] && m_r) begin
          if (exp_q[owner].size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q[owner].pop_front();
            chk("sb_beat", {m_l, m_d}, e);
          end
          if (owner == 0) hs0_cyc_q.push_back(cyc);
          if (l[owner]) begin
            order_q.push_back(owner);
            mcnt[owner] = (mcnt[owner] + 1) % (1 << CW);
            prio = 1 - owner;
            owner = -1;
          end
        end
      end else if (rst_n) begin
        if (v[0] && v[1]) owner = prio;
        else if (v[0]) owner = 0;
        else if (v[1]) owner = 1;
      end
    end
  end

  task automatic wait_idle(int budget);
    int n = 0;
    bit idle;
    do begin
      @(negedge clk);
      #1;
      n++;
      idle = (owner < 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0);
    end while (!idle && n < budget);
    chk("idle_timeout", idle, 1);
  endtask

  initial begin
    int t0;
    int n;
    // T1: reset held with both sources valid; contention packets are queued already.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq(0, 2, 8'hA0 + 2 * k, 0);
      enq(1, 2, 8'hB0 + 2 * k, 0);
    end
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;

    // T3: strict alternation starting at port 0.
    wait_idle(200);
    chk("t3_order_len", order_q.size(), 6);
    for (int i = 0; i < order_q.size(); i++) chk("t3_order", order_q[i], i % 2);
    chk("t3_cnt0", cnt0, 3);
    chk("t3_cnt1", cnt1, 3);

    // T2: lone port-0 packet 0x10..0x13 on consecutive cycles, one cycle after TVALID.
    hs0_cyc_q.delete();
    @(posedge clk);
    #2;
    t0 = cyc + 1;
    enq(0, 4, 8'h10, 0);
    wait_idle(100);
    chk("t2_beats", hs0_cyc_q.size(), 4);
    if (hs0_cyc_q.size() == 4) begin
      chk("t2_latency", hs0_cyc_q[0] - t0, 1);
      chk("t2_span", hs0_cyc_q[3] - hs0_cyc_q[0], 3);
    end
    chk("t2_cnt0", cnt0, 4);

    // T4: 8-beat port-1 packet under random backpressure.
    rand_ready = 1;
    @(posedge clk);
    #2;
    enq(1, 8, 8'hC0, 0);
    wait_idle(400);
    rand_ready = 0;
    chk("t4_all_beats", exp_q[1].size(), 0);
    chk("t4_cnt1", cnt1, 4);

    // T6: reset after two beats of a four-beat packet, then a fresh packet.
    @(posedge clk);
    #2;
    enq(0, 4, 8'hD0, 0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (exp_q[0].size() > 2 && n < 50);
    chk("t6_reach_beat2", exp_q[0].size(), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    src_q[0].delete();
    exp_q[0].delete();
    drive_src();
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    enq(0, 3, 8'hE0, 0);
    wait_idle(100);
    chk("t6_cnt0", cnt0, 1);
    chk("t6_cnt1", cnt1, 0);

    // Random traffic: random lengths, gaps, data and sink stalls.
    rand_gaps = 1;
    rand_ready = 1;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      @(posedge clk);
      #2;
      enq($urandom_range(0, 1), $urandom_range(1, 5), 0, 1);
    end
    wait_idle(3000);
    rand_ready = 0;
    chk("final_sb0_empty", exp_q[0].size(), 0);
    chk("final_sb1_empty", exp_q[1].size(), 0);
    chk("final_cnt_total", cnt0 + cnt1, mcnt[0] + mcnt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
